pipelined_radix4_booth_wallace53: RTL and testbench

PIPELINED_RADIX4_BOOTH_WALLACE53 -- requirements
Module: pipelined_radix4_booth_wallace53

---
 rtl/pipelined_radix4_booth_wallace53_pkg.sv | 31 +++
 rtl/pipelined_radix4_booth_wallace53_if.sv | 22 ++
 rtl/pipelined_radix4_booth_wallace53_pp_gen.sv | 36 +++
 rtl/pipelined_radix4_booth_wallace53.sv | 145 ++++++++++++++
 tb/tb_pipelined_radix4_booth_wallace53.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/pipelined_radix4_booth_wallace53_pkg.sv
// Shared constants, Booth digit type and triplet decoder for the radix-4 Booth / Wallace multiplier.
package pipelined_radix4_booth_wallace53_pkg;

  localparam int unsigned WIDTH        = 53;
  localparam int unsigned PROD_W       = 2 * WIDTH;
  localparam int unsigned EXT_W        = WIDTH + 2;
  localparam int unsigned BOOTH_DIGITS = 28;
  localparam int unsigned NUM_STAGES   = 4;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd5,
    BOOTH_M2   = 3'd6
  } booth_digit_e;

  // Overlapping triplet {y[2i+1], y[2i], y[2i-1]} to digit in {-2..+2}.
  function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
    booth_digit_e digit;
    case (triplet)
      3'b001, 3'b010: digit = BOOTH_P1;
      3'b011:         digit = BOOTH_P2;
      3'b100:         digit = BOOTH_M2;
      3'b101, 3'b110: digit = BOOTH_M1;
      default:        digit = BOOTH_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/pipelined_radix4_booth_wallace53_if.sv
// Operand/result bus of the pipelined multiplier; PIPELINED_MULT_VALID_EN adds outValid.
interface pipelined_radix4_booth_wallace53_if #(
  parameter int unsigned WIDTH = pipelined_radix4_booth_wallace53_pkg::WIDTH
);

  logic                 run;
  logic                 signedFlag;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   out;

`ifdef PIPELINED_MULT_VALID_EN
  logic                 outValid;

  modport master (output run, signedFlag, multiplicand, multiplier, input out, outValid);
  modport slave  (input run, signedFlag, multiplicand, multiplier, output out, outValid);
`else
  modport master (output run, signedFlag, multiplicand, multiplier, input out);
  modport slave  (input run, signedFlag, multiplicand, multiplier, output out);
`endif

endinterface

// File: rtl/pipelined_radix4_booth_wallace53_pp_gen.sv
// One radix-4 Booth digit times the extended multiplicand: inverted magnitude plus a +1 correction bit when negative.
module radix4_booth_pp_gen
  import pipelined_radix4_booth_wallace53_pkg::*;
#(
  parameter int unsigned XW = pipelined_radix4_booth_wallace53_pkg::EXT_W
) (
  input  logic [2:0]    triplet,
  input  logic [XW-1:0] x_ext,
  output logic [XW:0]   pp_c,
  output logic          neg_c
);

  booth_digit_e digit;
  logic [XW:0]  mag;

  always_comb begin
    digit = booth_decode(triplet);
    mag   = '0;
    neg_c = 1'b0;
    case (digit)
      BOOTH_P1: mag = {x_ext[XW-1], x_ext};
      BOOTH_P2: mag = {x_ext, 1'b0};
      BOOTH_M1: begin
        mag   = {x_ext[XW-1], x_ext};
        neg_c = 1'b1;
      end
      BOOTH_M2: begin
        mag   = {x_ext, 1'b0};
        neg_c = 1'b1;
      end
      default:  mag = '0;
    endcase
    pp_c = neg_c ? ~mag : mag;
  end

endmodule

// File: rtl/pipelined_radix4_booth_wallace53.sv
// 4-stage signed/unsigned multiplier: capture, Booth partial products, CSA tree, final add.
// Optional PIPELINED_MULT_VALID_EN adds a valid shift register driving outValid.
module pipelined_radix4_booth_wallace53
  import pipelined_radix4_booth_wallace53_pkg::*;
#(
  parameter int unsigned WIDTH = pipelined_radix4_booth_wallace53_pkg::WIDTH
) (
  input  logic clk,
  input  logic rst,
  pipelined_radix4_booth_wallace53_if.slave bus
);

  localparam int unsigned XW         = WIDTH + 2;
  localparam int unsigned PW         = 2 * WIDTH;
  localparam int unsigned ND         = (XW + 1) / 2;
  localparam int unsigned YW         = 2 * ND;
  localparam int unsigned PPW        = XW + 1;
  localparam int unsigned NR         = ND + 1;
  localparam int unsigned CSA_LEVELS = 10;

  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             sf_q, sf_d;
  logic [PPW-1:0]   pp_q [ND];
  logic [PPW-1:0]   pp_d [ND];
  logic [PPW-1:0]   pp_c [ND];
  logic [ND-1:0]    neg_q, neg_d, neg_c;
  logic [PW-1:0]    sum_q, sum_d, carry_q, carry_d, out_q, out_d;
  logic [PW-1:0]    sum_c, carry_c;
  logic [XW-1:0]    x_ext, y_ext;
  logic [YW:0]      y_pad;

  // Operand extension; the flag travels with its operands from S1.
  always_comb begin
    x_ext = {{2{sf_q & x_q[WIDTH-1]}}, x_q};
    y_ext = {{2{sf_q & y_q[WIDTH-1]}}, y_q};
    y_pad = {YW'($signed(y_ext)), 1'b0};
  end

  for (genvar i = 0; i < ND; i++) begin : g_pp
    radix4_booth_pp_gen #(.XW(XW)) u_pp (
      .triplet (y_pad[2*i+2 -: 3]),
      .x_ext   (x_ext),
      .pp_c    (pp_c[i]),
      .neg_c   (neg_c[i])
    );
  end

  // 3:2 compressor tree over the shifted partial products plus the correction-bit row.
  always_comb begin : csa_tree
    logic [PW-1:0] rows [NR];
    logic [PW-1:0] nxt  [NR];
    logic [PW-1:0] a, b, c;
    int            n;
    int            base;
    rows = '{default: '0};
    for (int i = 0; i < ND; i++) begin
      rows[i]          = PW'($signed(pp_q[i])) << (2 * i);
      rows[ND][2 * i]  = neg_q[i];
    end
    n = NR;
    for (int lvl = 0; lvl < CSA_LEVELS; lvl++) begin
      nxt  = '{default: '0};
      base = n / 3;
      for (int g = 0; g < NR / 3; g++) begin
        if (g < base) begin
          a              = rows[3*g];
          b              = rows[3*g+1];
          c              = rows[3*g+2];
          nxt[2*g]       = a ^ b ^ c;
          nxt[2*g+1]     = ((a & b) | (a & c) | (b & c)) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (3 * base + r < n) nxt[2*base+r] = rows[3*base+r];
      end
      rows = nxt;
      n    = 2 * base + (n % 3);
    end
    sum_c   = rows[0];
    carry_c = rows[1];
  end

  // All ranks advance together on run; otherwise everything holds.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    sf_d    = sf_q;
    pp_d    = pp_q;
    neg_d   = neg_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    out_d   = out_q;
    if (bus.run) begin
      x_d     = bus.multiplicand;
      y_d     = bus.multiplier;
      sf_d    = bus.signedFlag;
      pp_d    = pp_c;
      neg_d   = neg_c;
      sum_d   = sum_c;
      carry_d = carry_c;
      out_d   = sum_q + carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      sf_q    <= 1'b0;
      pp_q    <= '{default: '0};
      neg_q   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      out_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sf_q    <= sf_d;
      pp_q    <= pp_d;
      neg_q   <= neg_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      out_q   <= out_d;
    end
  end

  assign bus.out = out_q;

`ifdef PIPELINED_MULT_VALID_EN
  logic [NUM_STAGES-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (bus.run) vld_d = {vld_q[NUM_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign bus.outValid = vld_q[NUM_STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_radix4_booth_wallace53.sv
// Directed and random scoreboard bench for the pipelined Booth/Wallace multiplier.
module tb_pipelined_radix4_booth_wallace53;

  logic clk;
  logic rst;

  pipelined_radix4_booth_wallace53_if bus ();

  pipelined_radix4_booth_wallace53 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_assert;
  int            n_fail;
  logic [105:0]  sb [$];
  logic [3:0]    vpipe;
  logic [105:0]  held;
  logic [105:0]  ones106;
  logic [52:0]   all1;
  logic [52:0]   min53;

  function automatic logic [105:0] model(input logic s, input logic [52:0] x, input logic [52:0] y);
    logic [105:0] xe;
    logic [105:0] ye;
    xe = s ? {{53{x[52]}}, x} : {53'd0, x};
    ye = s ? {{53{y[52]}}, y} : {53'd0, y};
    return xe * ye;
  endfunction

  task automatic chk(input string tag, input logic [105:0] obs, input logic [105:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; on run edges the expected product enters the scoreboard.
  task automatic tick(input logic r, input logic s, input logic [52:0] x, input logic [52:0] y,
                      input logic [105:0] exp);
    bus.run          = r;
    bus.signedFlag   = s;
    bus.multiplicand = x;
    bus.multiplier   = y;
    @(posedge clk);
    if (r) begin
      vpipe = {vpipe[2:0], 1'b1};
      sb.push_back(exp);
    end
    #1;
    if (r && vpipe[3]) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", bus.out, ~bus.out);
      end else begin
        held = sb.pop_front();
        chk("product", bus.out, held);
      end
    end else if (!r) begin
      chk("stall_hold", bus.out, held);
    end else begin
      chk("fill_zero", bus.out, held);
    end
`ifdef PIPELINED_MULT_VALID_EN
    chk("out_valid", 106'(bus.outValid), 106'(vpipe[3]));
`endif
  endtask

  task automatic rnd_tick(input logic r);
    logic        s;
    logic [52:0] x;
    logic [52:0] y;
    s = 1'($urandom_range(0, 1));
    x = 53'({$urandom(), $urandom()});
    y = 53'({$urandom(), $urandom()});
    tick(r, s, x, y, model(s, x, y));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    chk("reset_async", bus.out, 106'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", bus.out, 106'd0);
`ifdef PIPELINED_MULT_VALID_EN
    chk("reset_valid", 106'(bus.outValid), 106'd0);
`endif
    rst = 1'b0;
    sb.delete();
    vpipe = '0;
    held  = '0;
  endtask

  initial begin
    n_assert         = 0;
    n_fail           = 0;
    vpipe            = '0;
    held             = '0;
    ones106          = '1;
    all1             = '1;
    min53            = 53'd1 << 52;
    rst              = 1'b0;
    bus.run          = 1'b0;
    bus.signedFlag   = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #1;
    pulse_reset();

    // Corner products from the requirements, then additional corners.
    tick(1'b1, 1'b0, all1,  all1,  (ones106 << 54) + 106'd1);
    tick(1'b1, 1'b1, all1,  all1,  106'd1);
    tick(1'b1, 1'b1, all1,  53'd1, ones106);
    tick(1'b1, 1'b1, min53, min53, 106'd1 << 104);
    tick(1'b1, 1'b0, min53, min53, 106'd1 << 104);
    tick(1'b1, 1'b1, min53, all1,  106'd1 << 52);
    tick(1'b1, 1'b1, min53, 53'd1, ones106 << 52);
    tick(1'b1, 1'b0, 53'd0, all1,  106'd0);
    tick(1'b1, 1'b1, all1,  53'd0, 106'd0);
    tick(1'b1, 1'b0, all1,  53'd1, {53'd0, all1});

    // Back-to-back stream with mixed signedness.
    for (int i = 0; i < 12; i++) rnd_tick(1'b1);

    // Three-cycle stall mid-stream, then resume.
    for (int i = 0; i < 3; i++) rnd_tick(1'b0);
    for (int i = 0; i < 6; i++) rnd_tick(1'b1);

    // Reset with operations in flight; first new product after four run edges.
    pulse_reset();
    for (int i = 0; i < 6; i++) rnd_tick(1'b1);
    rnd_tick(1'b0);
    for (int i = 0; i < 4; i++) rnd_tick(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
